// File: rtl/fetch_queue_stage_pkg.sv
// fetch_queue_stage_pkg: shared widths, reset PC, zero instruction and queue entry type
package fetch_queue_stage_pkg;
  localparam int XLEN_D = 32;
  localparam int ILEN_D = 32;
  localparam int DEPTH_D = 4;
  localparam logic [XLEN_D-1:0] RESET_PC_D = 32'h0000_0000;
  localparam logic [ILEN_D-1:0] ZERO_INSTR = '0;
  typedef struct packed {
    logic [XLEN_D-1:0] pc;
    logic [ILEN_D-1:0] instr;
    logic              filled;
  } fq_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: in-order prefetch queue; entries allocated at request, filled by responses, consumed at head
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN = 32,
  parameter int ILEN = 32,
  localparam int AW = $clog2(DEPTH)
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_all,
  input  logic            alloc,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill,
  input  logic [ILEN-1:0] fill_data,
  input  logic            pop,
  output logic            head_filled,
  output logic [XLEN-1:0] head_pc,
  output logic [ILEN-1:0] head_instr,
  output logic [AW:0]     occupancy,
  output logic [AW:0]     unfilled
);
  logic [AW:0] alloc_ptr, fill_ptr, head_ptr;
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [ILEN-1:0] instr_mem [DEPTH];
  // the extra pointer bit separates full from empty; an entry is filled once fill_ptr has passed it
  assign occupancy = alloc_ptr - head_ptr;
  assign unfilled = alloc_ptr - fill_ptr;
  assign head_filled = fill_ptr != head_ptr;
  assign head_pc = pc_mem[head_ptr[AW-1:0]];
  assign head_instr = instr_mem[head_ptr[AW-1:0]];
  always_ff @(posedge clk)
    if (rst || flush_all) begin
      alloc_ptr <= '0;
      fill_ptr <= '0;
      head_ptr <= '0;
    end else begin
      alloc_ptr <= alloc_ptr + (AW+1)'(alloc);
      fill_ptr <= fill_ptr + (AW+1)'(fill);
      head_ptr <= head_ptr + (AW+1)'(pop);
    end
  always_ff @(posedge clk) begin
    if (alloc) pc_mem[alloc_ptr[AW-1:0]] <= alloc_pc;
    if (fill) instr_mem[fill_ptr[AW-1:0]] <= fill_data;
  end
endmodule

// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: PC generation, imem request issue and IF/ID register over a prefetch queue
module fetch_queue_stage
  import fetch_queue_stage_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int ILEN = ILEN_D,
  parameter int DEPTH = DEPTH_D,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_D
)(
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic [XLEN-1:0] PCF,
  output logic [ILEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] occupancy, unfilled, drop_cnt;
  logic [AW+1:0] in_flight;
  logic head_filled, req_fire, rsp_fill, load_d;
  logic [XLEN-1:0] head_pc;
  logic [ILEN-1:0] head_instr;
  // stale responses still owed by memory count against capacity, keeping the drop counter within DEPTH
  assign in_flight = {1'b0, occupancy} + {1'b0, drop_cnt};
  assign imem_req_valid = ~reset & ~StallF & ~PCSrcE & (in_flight < (AW+2)'(DEPTH));
  assign imem_req_addr = PCF;
  assign req_fire = imem_req_valid & imem_req_ready;
  assign rsp_fill = imem_rsp_valid & (drop_cnt == '0) & ~PCSrcE;
  assign load_d = ~FlushD & ~StallD & head_filled;
  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .ILEN(ILEN)) u_queue (
    .clk(clk),
    .rst(reset),
    .flush_all(PCSrcE),
    .alloc(req_fire),
    .alloc_pc(PCF),
    .fill(rsp_fill),
    .fill_data(imem_rsp_data),
    .pop(load_d),
    .head_filled(head_filled),
    .head_pc(head_pc),
    .head_instr(head_instr),
    .occupancy(occupancy),
    .unfilled(unfilled)
  );
  always_ff @(posedge clk)
    if (reset) begin
      PCF <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      PCF <= PCSrcE ? PCTargetE : req_fire ? PCF + XLEN'(4) : PCF;
      drop_cnt <= PCSrcE ? drop_cnt + unfilled - (AW+1)'(imem_rsp_valid)
                : (imem_rsp_valid && drop_cnt != '0) ? drop_cnt - (AW+1)'(1) : drop_cnt;
    end
  always_ff @(posedge clk)
    if (reset) begin
      InstrD <= '0;
      PCD <= '0;
      PCPlus4D <= '0;
      ValidD <= 1'b0;
    end else if (FlushD) begin
      ValidD <= 1'b0;
      InstrD <= ILEN'(ZERO_INSTR);
    end else if (!StallD) begin
      ValidD <= head_filled;
      InstrD <= head_filled ? head_instr : ILEN'(ZERO_INSTR);
      if (head_filled) begin
        PCD <= head_pc;
        PCPlus4D <= head_pc + XLEN'(4);
      end
    end
  assert property (@(posedge clk) disable iff (reset) imem_rsp_valid |-> (drop_cnt != '0 || unfilled != '0));
  assert property (@(posedge clk) disable iff (reset) drop_cnt <= (AW+1)'(DEPTH));
endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb_fetch_queue_stage: table vectors, directed corner cases and a randomized run against a queue-level model
module tb_fetch_queue_stage;
  import fetch_queue_stage_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 0, reset = 1, StallF = 0, StallD = 0, FlushD = 0, PCSrcE = 0;
  logic imem_req_ready = 1, imem_rsp_valid = 0;
  logic [31:0] PCTargetE = 0, imem_rsp_data = 0;
  logic imem_req_valid, ValidD;
  logic [31:0] imem_req_addr, PCF, InstrD, PCD, PCPlus4D;

  always #5 clk = ~clk;

  fetch_queue_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .PCF(PCF),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { bit rst; bit sd; bit fd; bit ev; logic [31:0] ea; bit evd; logic [31:0] epcd; } vec_t;

  fq_entry_t m_q[$];
  mreq_t mem_q[$];
  int m_drop, cyc, last_due, lat = 1, errors, checks;
  logic m_valid;
  logic [31:0] m_pcf, m_instr, m_pcd, m_pcp4;

  function automatic logic [31:0] instr_of(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // queue-level model: entries hold pc/instr/filled; memory is a list of owed addresses
  task automatic model_update(input bit fire);
    if (reset) begin
      m_q.delete(); mem_q.delete();
      m_drop = 0; m_pcf = 0; m_valid = 0; m_instr = 0; m_pcd = 0; m_pcp4 = 0; last_due = cyc;
      return;
    end
    if (FlushD) begin
      m_valid = 0; m_instr = 0;
    end else if (!StallD) begin
      if (m_q.size() > 0 && m_q[0].filled) begin
        m_valid = 1; m_instr = m_q[0].instr; m_pcd = m_q[0].pc; m_pcp4 = m_q[0].pc + 4;
        void'(m_q.pop_front());
      end else begin
        m_valid = 0; m_instr = 0;
      end
    end
    if (imem_rsp_valid) begin
      if (m_drop > 0) m_drop--;
      else
        for (int i = 0; i < m_q.size(); i++)
          if (!m_q[i].filled) begin
            m_q[i].filled = 1'b1;
            m_q[i].instr = imem_rsp_data;
            break;
          end
      void'(mem_q.pop_front());
    end
    if (PCSrcE) begin
      for (int i = 0; i < m_q.size(); i++) if (!m_q[i].filled) m_drop++;
      m_q.delete();
      m_pcf = PCTargetE;
    end else if (fire) begin
      m_q.push_back('{pc: m_pcf, instr: 32'h0, filled: 1'b0});
      last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      mem_q.push_back('{addr: m_pcf, due: last_due});
      m_pcf = m_pcf + 4;
    end
  endtask

  task automatic step(output logic s_v, output logic [31:0] s_addr);
    logic exp_v;
    if (!reset && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1; imem_rsp_data = instr_of(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 0; imem_rsp_data = $urandom;
    end
    #1;
    s_v = imem_req_valid;
    s_addr = imem_req_addr;
    exp_v = !reset && !StallF && !PCSrcE && (m_q.size() + m_drop < DEPTH);
    check("req_valid", imem_req_valid, exp_v);
    if (!reset) check("req_addr", imem_req_addr, m_pcf);
    model_update(exp_v && imem_req_ready);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check("PCF", PCF, m_pcf);
    check("ValidD", ValidD, m_valid);
    if (m_valid) begin
      check("PCD", PCD, m_pcd);
      check("PCPlus4D", PCPlus4D, m_pcp4);
      check("InstrD", InstrD, m_instr);
    end else check("InstrD_zero", InstrD, 0);
  endtask

  task automatic do_reset();
    logic v;
    logic [31:0] a;
    StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; imem_req_ready = 1; lat = 1;
    reset = 1;
    step(v, a);
    reset = 0;
  endtask

  initial begin
    vec_t tbl[10];
    logic sv;
    logic [31:0] sa, held, held_i, prev;
    int got;
    tbl[0] = '{1, 0, 0, 0, 32'h00, 0, 32'h00};
    tbl[1] = '{0, 0, 0, 1, 32'h00, 0, 32'h00};
    tbl[2] = '{0, 0, 0, 1, 32'h04, 0, 32'h00};
    tbl[3] = '{0, 0, 0, 1, 32'h08, 1, 32'h00};
    tbl[4] = '{0, 0, 0, 1, 32'h0C, 1, 32'h04};
    tbl[5] = '{0, 1, 0, 1, 32'h10, 1, 32'h04};
    tbl[6] = '{0, 1, 1, 1, 32'h14, 0, 32'h00};
    tbl[7] = '{0, 0, 0, 0, 32'h18, 1, 32'h08};
    tbl[8] = '{0, 0, 0, 1, 32'h18, 1, 32'h0C};
    tbl[9] = '{0, 0, 0, 1, 32'h1C, 1, 32'h10};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      reset = tbl[i].rst; StallD = tbl[i].sd; FlushD = tbl[i].fd;
      step(sv, sa);
      check("tbl_req_valid", sv, tbl[i].ev);
      if (!tbl[i].rst) check("tbl_req_addr", sa, tbl[i].ea);
      check("tbl_ValidD", ValidD, tbl[i].evd);
      if (tbl[i].evd) begin
        check("tbl_PCD", PCD, tbl[i].epcd);
        check("tbl_InstrD", InstrD, instr_of(tbl[i].epcd));
      end else check("tbl_InstrD_zero", InstrD, 0);
    end
    StallD = 0; FlushD = 0;

    // decode held while the queue fills under 3-cycle memory, then an unbroken PC stream
    do_reset();
    lat = 3;
    repeat (6) step(sv, sa);
    StallD = 1;
    repeat (3) step(sv, sa);
    held = PCD;
    held_i = InstrD;
    for (int i = 0; i < 5; i++) begin
      step(sv, sa);
      check("stall_no_req", sv, 0);
      check("stall_PCD", PCD, held);
      check("stall_InstrD", InstrD, held_i);
    end
    StallD = 0;
    prev = held;
    got = 0;
    for (int i = 0; i < 30 && got < 6; i++) begin
      step(sv, sa);
      if (ValidD) begin
        check("stream_PCD", PCD, prev + 4);
        prev = PCD;
        got++;
      end
    end
    check("stream_count", got, 6);

    // redirect with three requests in flight
    do_reset();
    lat = 5;
    repeat (3) step(sv, sa);
    PCSrcE = 1; PCTargetE = 32'h100; FlushD = 1;
    step(sv, sa);
    check("redir_no_req", sv, 0);
    PCSrcE = 0; FlushD = 0;
    check("redir_PCF", PCF, 32'h100);
    step(sv, sa);
    check("redir_req_valid", sv, 1);
    check("redir_req_addr", sa, 32'h100);
    for (int i = 0; i < 40 && !ValidD; i++) step(sv, sa);
    check("redir_first_valid", ValidD, 1);
    check("redir_first_PCD", PCD, 32'h100);
    check("redir_first_InstrD", InstrD, instr_of(32'h100));

    // reset in the middle of a stream with requests outstanding
    lat = 2;
    repeat (4) step(sv, sa);
    reset = 1;
    step(sv, sa);
    reset = 0;
    check("rst_PCF", PCF, 32'h0);
    check("rst_ValidD", ValidD, 0);
    check("rst_PCD", PCD, 32'h0);
    step(sv, sa);
    check("rst_req_valid", sv, 1);
    check("rst_req_addr", sa, 32'h0);

    do_reset();
    for (int i = 0; i < 4000; i++) begin
      lat = $urandom_range(1, 4);
      reset = ($urandom_range(0, 199) == 0);
      StallF = ($urandom_range(0, 9) == 0);
      StallD = ($urandom_range(0, 4) == 0);
      PCSrcE = ($urandom_range(0, 24) == 0);
      FlushD = PCSrcE ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 14) == 0);
      PCTargetE = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & ~32'h3);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      step(sv, sa);
    end
    reset = 0; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
